// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button press classifier: state encodings,
// default tick constants and the per-cycle event bundle.
package button_press_classifier_pkg;

  // Classifier states (2-bit, kept as plain constants for legacy tools)
  localparam logic [1:0] ST_WAIT_REL  = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_LONG_HELD = 2'd3;

  // Default timing for a 50 MHz system clock: 1 s long press, 200 ms repeat
  localparam int DEFAULT_LONG_TICKS   = 50_000_000;
  localparam int DEFAULT_REPEAT_TICKS = 10_000_000;
  localparam int DEFAULT_CNT_W        = 26;

  // One bit per single-cycle event pulse
  typedef struct packed {
    logic press;
    logic rel;
    logic short_rel;
    logic long_hold;
    logic rpt;
  } event_t;

  // Quiet cycle: no event pulses
  function automatic event_t no_events();
    event_t ev;
    ev.press     = 1'b0;
    ev.rel       = 1'b0;
    ev.short_rel = 1'b0;
    ev.long_hold = 1'b0;
    ev.rpt       = 1'b0;
    return ev;
  endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Button level in, classified event pulses and status out.
interface button_press_classifier_if;
  logic       button_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;

  // Side that supplies the button level and consumes the events
  modport master (
    output button_in,
    input  press_pulse, release_pulse, short_pulse, long_pulse,
           repeat_pulse, held, press_count
  );

  // The classifier itself
  modport slave (
    input  button_in,
    output press_pulse, release_pulse, short_pulse, long_pulse,
           repeat_pulse, held, press_count
  );
endinterface

// File: rtl/button_press_classifier_hold_timer.sv
// Hold-duration counter: synchronous clear (priority) and count enable,
// with a terminal-count flag raised when count reaches limit-1.
module button_press_classifier_hold_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Count held cycles; clear wins over enable
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  // Terminal count against the currently selected limit
  always_comb begin
    tc = (count == (limit - CNT_W'(1)));
  end

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into single-cycle press / release /
// short / long / repeat pulses plus a held flag and a wrapping press count.
// A level already high when reset releases is ignored until it drops.
module button_press_classifier
  import button_press_classifier_pkg::*;
#(
  parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
  parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input logic                        clk_in,
  input logic                        rst_in,
  button_press_classifier_if.slave   bus
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  event_t           events;
  event_t           events_nxt;
  logic             held_flag;
  logic             held_nxt;
  logic [7:0]       count;
  logic [7:0]       count_nxt;
  logic             timer_clear;
  logic             timer_enable;
  logic             timer_tc;
  logic [CNT_W-1:0] timer_limit;

  button_press_classifier_hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (timer_limit),
    .tc     (timer_tc)
  );

  // Long threshold while first held, repeat period once long-held
  always_comb begin
    if (state == ST_LONG_HELD) begin
      timer_limit = CNT_W'(REPEAT_TICKS);
    end else begin
      timer_limit = CNT_W'(LONG_TICKS);
    end
  end

  // Next state, next event pulses, press counter and timer control.
  // A release seen on a threshold edge takes precedence over long/repeat.
  always_comb begin
    state_nxt    = state;
    events_nxt   = no_events();
    count_nxt    = count;
    timer_clear  = 1'b1;
    timer_enable = 1'b0;
    case (state)
      ST_WAIT_REL: begin
        if (!bus.button_in) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_REL;
        end
      end
      ST_IDLE: begin
        if (bus.button_in) begin
          state_nxt        = ST_PRESSED;
          events_nxt.press = 1'b1;
          count_nxt        = count + 8'd1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (!bus.button_in) begin
          state_nxt            = ST_IDLE;
          events_nxt.rel       = 1'b1;
          events_nxt.short_rel = 1'b1;
        end else if (timer_tc) begin
          state_nxt            = ST_LONG_HELD;
          events_nxt.long_hold = 1'b1;
        end else begin
          timer_clear  = 1'b0;
          timer_enable = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!bus.button_in) begin
          state_nxt      = ST_IDLE;
          events_nxt.rel = 1'b1;
        end else if (timer_tc) begin
          events_nxt.rpt = 1'b1;
        end else begin
          timer_clear  = 1'b0;
          timer_enable = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_WAIT_REL;
      end
    endcase
    held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_LONG_HELD);
  end

  // State and registered outputs; reset lands in WAIT_REL with no pulses
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_WAIT_REL;
      events    <= no_events();
      held_flag <= 1'b0;
      count     <= 8'd0;
    end else begin
      state     <= state_nxt;
      events    <= events_nxt;
      held_flag <= held_nxt;
      count     <= count_nxt;
    end
  end

  assign bus.press_pulse   = events.press;
  assign bus.release_pulse = events.rel;
  assign bus.short_pulse   = events.short_rel;
  assign bus.long_pulse    = events.long_hold;
  assign bus.repeat_pulse  = events.rpt;
  assign bus.held          = held_flag;
  assign bus.press_count   = count;

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench for button_press_classifier with LONG_TICKS=8,
// REPEAT_TICKS=4. A behavioural model counts edges since the press and
// pushes the expected outputs for every clock edge; a monitor pops and
// compares on the falling edge.
module tb_button_press_classifier;

  localparam int LONG = 8;
  localparam int REP  = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  int   press_seen = 0;
  int   base = 0;
  logic [12:0] exp_q[$];

  button_press_classifier_if bus();

  button_press_classifier #(
    .LONG_TICKS   (LONG),
    .REPEAT_TICKS (REP),
    .CNT_W        (4)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: armed after a release is seen, then counts edges held
  initial begin : model
    bit armed;
    bit down;
    int hold;
    logic [7:0] mcount;
    logic b, p, r, s, l, rp;
    armed = 1'b0; down = 1'b0; hold = 0; mcount = 8'd0;
    forever begin
      @(posedge clk_in);
      if (rst_in) begin
        armed = 1'b0; down = 1'b0; hold = 0; mcount = 8'd0;
        exp_q.push_back(13'd0);
      end else begin
        b = bus.button_in;
        p = 1'b0; r = 1'b0; s = 1'b0; l = 1'b0; rp = 1'b0;
        if (!armed) begin
          if (!b) armed = 1'b1;
        end else if (!down) begin
          if (b) begin
            down = 1'b1; hold = 0; p = 1'b1; mcount = mcount + 8'd1;
          end
        end else begin
          hold = hold + 1;
          if (!b) begin
            r = 1'b1; s = (hold <= LONG); down = 1'b0;
          end else begin
            l  = (hold == LONG);
            rp = (hold > LONG) && (((hold - LONG) % REP) == 0);
          end
        end
        exp_q.push_back({p, r, s, l, rp, down, mcount});
      end
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation
  initial begin : monitor
    logic [12:0] e;
    logic [12:0] g;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {bus.press_pulse, bus.release_pulse, bus.short_pulse, bus.long_pulse,
             bus.repeat_pulse, bus.held, bus.press_count};
        checks++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got p/r/s/l/rp/h/cnt=%b required=%b", $time, g, e);
        end
        if (bus.press_pulse === 1'b1) press_seen++;
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic drive(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.button_in = b;
      @(negedge clk_in);
    end
  endtask

  // Reset asserted just after a rising edge: outputs must clear at once
  task automatic async_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    exp_q.delete();
    #1;
    check("rst_pulses_held",
          int'({bus.press_pulse, bus.release_pulse, bus.short_pulse,
                bus.long_pulse, bus.repeat_pulse, bus.held}), 0);
    check("rst_count", int'(bus.press_count), 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    bus.button_in = 1'b1;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    // Level held across reset must never count as a press
    drive(1'b1, 20);
    drive(1'b0, 3);
    #1;
    check("stuck_count", int'(bus.press_count), 0);
    check("stuck_presses", press_seen, 0);
    drive(1'b1, 2);
    drive(1'b0, 2);
    #1;
    check("first_count", int'(bus.press_count), 1);
    check("first_presses", press_seen, 1);

    // One-edge press, long hold with repeats, release on long threshold
    drive(1'b1, 1);
    drive(1'b0, 3);
    drive(1'b1, 20);
    drive(1'b0, 3);
    drive(1'b1, 8);
    drive(1'b0, 3);
    #1;
    check("directed_count", int'(bus.press_count), 4);

    // 256 short presses from a clean reset wrap the count to zero
    rst_in = 1'b1;
    drive(1'b0, 2);
    rst_in = 1'b0;
    drive(1'b0, 2);
    base = press_seen;
    repeat (256) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b0, 2);
    #1;
    check("wrap_count", int'(bus.press_count), 0);
    check("wrap_presses", press_seen - base, 256);

    // Reset while long-held, button kept down afterwards
    drive(1'b1, 12);
    base = press_seen;
    async_reset();
    drive(1'b1, 6);
    #1;
    check("post_rst_presses", press_seen - base, 0);
    drive(1'b0, 2);
    drive(1'b1, 3);
    drive(1'b0, 2);
    #1;
    check("post_rst_count", int'(bus.press_count), 1);

    // Randomized holds and gaps with occasional resets
    for (int k = 0; k < 60; k++) begin
      drive(1'b1, int'($urandom_range(1, 22)));
      if ($urandom_range(0, 7) == 0) async_reset();
      drive(1'b0, int'($urandom_range(1, 3)));
    end
    drive(1'b0, 4);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
